div_arbiter: RTL and testbench



---
 rtl/div_arbiter_if.sv | 39 +++
 rtl/div_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester, response and shared-divider signals of div_arbiter.
// The slave modport is the arbiter's view; the master modport is the side that
// owns the requesters and the divider.
interface div_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int A_W   = 9,
    parameter int B_W   = 9,
    parameter int O_I_W = 4,
    parameter int O_F_W = 8
);
    localparam int O_W = O_I_W + O_F_W;

    // requester side
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [N_REQ-1:0]     req_ready;

    // shared divider
    logic [A_W-1:0]       div_a;
    logic [B_W-1:0]       div_b;
    logic [O_W-1:0]       div_o;

    // responses
    logic [N_REQ-1:0]     rsp_valid;
    logic [O_W-1:0]       rsp_o;
    logic                 rsp_dz;
    logic                 busy;

    modport slave (
        input  req_valid, req_a, req_b, div_o,
        output req_ready, div_a, div_b, rsp_valid, rsp_o, rsp_dz, busy
    );

    modport master (
        output req_valid, req_a, req_b, div_o,
        input  req_ready, div_a, div_b, rsp_valid, rsp_o, rsp_dz, busy
    );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one fixed-latency divider between
// N_REQ requesters. One grant per cycle, a DIV_LAT-deep tag pipeline routes
// each quotient back to the requester that issued it.
// Optional feature macro: DIV_ARB_ZERO_CHK_EN -- substitutes divisor 1 for a
// zero divisor and returns all-ones with rsp_dz set instead of the quotient.
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int A_W     = 9,
    parameter int B_W     = 9,
    parameter int O_I_W   = 4,
    parameter int O_F_W   = 8,
    parameter int DIV_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    div_arbiter_if.slave  bus
);
    localparam int O_W  = O_I_W + O_F_W;
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state_reg, state_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;

    logic [A_W-1:0]  op_a [N_REQ];
    logic [B_W-1:0]  op_b [N_REQ];

    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi_idx, lo_idx;
    logic [ID_W-1:0] grant_idx;
    logic            xfer;
    logic            dz_new;
    logic [B_W-1:0]  grant_b;

    logic            tag_vld_reg [DIV_LAT];
    logic [ID_W-1:0] tag_id_reg  [DIV_LAT];
    logic            tag_dz_reg  [DIV_LAT];
    logic            any_tag_vld;

    logic            out_vld;
    logic [ID_W-1:0] out_id;
    logic            out_dz;

    genvar gi;

    // Unpack the flat operand buses into per-requester words.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_a[gi] = bus.req_a[gi*A_W +: A_W];
            assign op_b[gi] = bus.req_b[gi*B_W +: B_W];
        end
    endgenerate

    // Round-robin search: the lowest valid index at or above the pointer wins,
    // otherwise wrap around to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) >= ptr_reg) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        xfer      = (hi_found | lo_found) & ~rst;
    end

    // One-hot grant, combinational from req_valid and the pointer.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = xfer && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Operand mux; an idle divider sees 0/1 so it never divides by zero.
    always_comb begin
        grant_b = op_b[grant_idx];
`ifdef DIV_ARB_ZERO_CHK_EN
        dz_new  = xfer && (grant_b == '0);
`else
        dz_new  = 1'b0;
`endif
        if (xfer) begin
            bus.div_a = op_a[grant_idx];
            bus.div_b = dz_new ? B_W'(1) : grant_b;
        end else begin
            bus.div_a = '0;
            bus.div_b = B_W'(1);
        end
    end

    // Pointer moves past the granted requester only when a transfer happens.
    always_comb begin
        ptr_next = ptr_reg;
        if (xfer) begin
            ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Tag pipeline mirroring the divider latency; stage 0 captures the grant.
    generate
        for (gi = 0; gi < DIV_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                // Load the tag of this cycle's transfer (or a bubble).
                always_ff @(posedge clk) begin
                    if (rst) begin
                        tag_vld_reg[0] <= 1'b0;
                        tag_id_reg[0]  <= '0;
                        tag_dz_reg[0]  <= 1'b0;
                    end else begin
                        tag_vld_reg[0] <= xfer;
                        tag_id_reg[0]  <= grant_idx;
                        tag_dz_reg[0]  <= dz_new;
                    end
                end
            end else begin : g_body
                // Shift tags one stage per cycle; no backpressure.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        tag_vld_reg[gi] <= 1'b0;
                        tag_id_reg[gi]  <= '0;
                        tag_dz_reg[gi]  <= 1'b0;
                    end else begin
                        tag_vld_reg[gi] <= tag_vld_reg[gi-1];
                        tag_id_reg[gi]  <= tag_id_reg[gi-1];
                        tag_dz_reg[gi]  <= tag_dz_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Any result still travelling through the divider keeps the block busy.
    always_comb begin
        any_tag_vld = 1'b0;
        for (int i = 0; i < DIV_LAT; i++) begin
            any_tag_vld = any_tag_vld | tag_vld_reg[i];
        end
    end

    // Next-state rule: transfer -> RUN, pending results -> DRAIN, else IDLE.
    always_comb begin
        if (xfer) begin
            state_next = RUN;
        end else if (any_tag_vld) begin
            state_next = DRAIN;
        end else begin
            state_next = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign bus.busy = ~rst && (state_reg != IDLE);

    // The emerging tag lines up with the quotient on div_o this cycle.
    assign out_vld = tag_vld_reg[DIV_LAT-1] & ~rst;
    assign out_id  = tag_id_reg[DIV_LAT-1];
    assign out_dz  = tag_dz_reg[DIV_LAT-1];

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
            assign bus.rsp_valid[gi] = out_vld && (out_id == ID_W'(gi));
        end
    endgenerate

    // Result and flag are forced to zero whenever no response is emerging.
    always_comb begin
        if (!out_vld) begin
            bus.rsp_o = '0;
        end else if (out_dz) begin
            bus.rsp_o = '1;
        end else begin
            bus.rsp_o = bus.div_o;
        end
`ifdef DIV_ARB_ZERO_CHK_EN
        bus.rsp_dz = out_vld & out_dz;
`else
        bus.rsp_dz = 1'b0;
`endif
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: scoreboard bench for div_arbiter with a behavioural
// fixed-latency divider. Grants, operands, busy and every response cycle are
// checked against an independent round-robin/latency model.
module tb_div_arbiter;
    localparam int N_REQ   = 4;
    localparam int A_W     = 9;
    localparam int B_W     = 9;
    localparam int O_I_W   = 4;
    localparam int O_F_W   = 8;
    localparam int O_W     = O_I_W + O_F_W;
    localparam int DIV_LAT = 2;
`ifdef DIV_ARB_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    div_arbiter_if #(.N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .O_I_W(O_I_W), .O_F_W(O_F_W)) bus ();

    div_arbiter #(
        .N_REQ(N_REQ), .A_W(A_W), .B_W(B_W),
        .O_I_W(O_I_W), .O_F_W(O_F_W), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural divider: unsigned a/b as fixed point, DIV_LAT cycles latency.
    function automatic logic [O_W-1:0] div_model(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        logic [A_W+O_F_W-1:0] num;
        if (b == '0) return 12'hABC;
        num = {a, {O_F_W{1'b0}}};
        return O_W'(num / (A_W+O_F_W)'(b));
    endfunction

    logic [O_W-1:0] dq [DIV_LAT];
    always @(posedge clk) begin
        dq[0] <= div_model(bus.div_a, bus.div_b);
        for (int k = 1; k < DIV_LAT; k++) dq[k] <= dq[k-1];
    end
    assign bus.div_o = dq[DIV_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    typedef struct {
        int             id;
        int             due;
        logic [O_W-1:0] o;
        logic           dz;
    } exp_t;

    exp_t sb[$];

    // Reference model state (only touched by the monitor process).
    int             m_ptr = 0;
    int             m_busy = 0;
    int             m_g;
    int             m_idx;
    logic           m_pend;
    logic [N_REQ-1:0] m_rdy;
    logic [A_W-1:0] m_a;
    logic [B_W-1:0] m_b;
    exp_t           m_e;

    // Monitor: sample on the falling edge, compare against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_rsp_o", 32'(bus.rsp_o), 32'd0);
            check("rst_rsp_dz", 32'(bus.rsp_dz), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            sb.delete();
            m_ptr  = 0;
            m_busy = 0;
        end else begin
            m_g = -1;
            for (int k = 0; k < N_REQ; k++) begin
                m_idx = (m_ptr + k) % N_REQ;
                if (m_g < 0 && bus.req_valid[m_idx]) m_g = m_idx;
            end
            m_rdy = '0;
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(m_rdy));
            check("busy", 32'(bus.busy), 32'(m_busy));

            m_pend = (sb.size() != 0);
            if (sb.size() != 0 && sb[0].due == cyc) begin
                m_e = sb.pop_front();
                $display("rsp cyc=%0d id=%0d rsp_o=%h rsp_dz=%b (want %h/%b)",
                         cyc, m_e.id, bus.rsp_o, bus.rsp_dz, m_e.o, m_e.dz);
                check("rsp_valid", 32'(bus.rsp_valid), 32'(1) << m_e.id);
                check("rsp_o", 32'(bus.rsp_o), 32'(m_e.o));
                check("rsp_dz", 32'(bus.rsp_dz), 32'(m_e.dz));
            end else begin
                check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("idle_rsp_o", 32'(bus.rsp_o), 32'd0);
                check("idle_rsp_dz", 32'(bus.rsp_dz), 32'd0);
            end

            if (m_g >= 0) begin
                m_a = bus.req_a[m_g*A_W +: A_W];
                m_b = bus.req_b[m_g*B_W +: B_W];
                check("div_a", 32'(bus.div_a), 32'(m_a));
                check("div_b", 32'(bus.div_b), (ZCHK && m_b == '0) ? 32'd1 : 32'(m_b));
                m_e.id  = m_g;
                m_e.due = cyc + DIV_LAT;
                m_e.dz  = ZCHK && (m_b == '0);
                m_e.o   = m_e.dz ? {O_W{1'b1}} : div_model(m_a, m_b);
                sb.push_back(m_e);
                m_ptr  = (m_g + 1) % N_REQ;
                m_busy = 1;
            end else begin
                check("idle_div_a", 32'(bus.div_a), 32'd0);
                check("idle_div_b", 32'(bus.div_b), 32'd1);
                m_busy = m_pend ? 1 : 0;
            end
        end
    end

    task automatic clr_req();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
    endtask

    task automatic set_req(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        bus.req_valid[i]          = 1'b1;
        bus.req_a[i*A_W +: A_W]   = a;
        bus.req_b[i*B_W +: B_W]   = b;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clr_req();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;

        // single request from requester 2: 6/3 -> 0x200
        set_req(2, 9'd6, 9'd3);
        tick(1);
        clr_req();
        tick(5);

        // back-to-back stream from requester 1
        for (int i = 0; i < 8; i++) begin
            clr_req();
            set_req(1, 9'(i + 1), 9'd1);
            tick(1);
        end
        clr_req();
        tick(4);

        // zero divisor
        set_req(3, 9'd5, 9'd0);
        tick(1);
        clr_req();
        tick(4);

        // reset one cycle after a transfer discards the result
        set_req(2, 9'd7, 9'd2);
        tick(1);
        clr_req();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // contention right after reset: grants 0,1,2,3,0,1
        for (int i = 0; i < N_REQ; i++) set_req(i, 9'(10 * (i + 1)), 9'(i + 2));
        tick(6);
        clr_req();
        tick(4);

        // random traffic, including dropped requests and zero divisors
        for (int t = 0; t < 60; t++) begin
            clr_req();
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, 9'($urandom_range(0, 511)),
                            ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 511)));
            end
            tick(1);
        end
        clr_req();
        tick(6);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
